// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state encodings.
// Build option: define AXI_RO_ID_REG_EN to make the top register a read-only ID word.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

`ifdef AXI_RO_ID_REG_EN
  localparam bit RO_ID_EN = 1'b1;
`else
  localparam bit RO_ID_EN = 1'b0;
`endif

endpackage

// File: rtl/axi4lite_slave_regfile_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R) with master and slave views.
interface axi4lite_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi4lite_slave_wr_ctrl.sv
// Write-path controller: pairs AW and W in either order, issues the register commit and the B response.
// Build option AXI_RO_ID_REG_EN: writes to the top index are dropped and answered with SLVERR.
module axi4lite_slave_wr_ctrl
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata_out
);

  wr_state_e             state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  ro_hit;

  // Readies depend on state only, so a master may legally wait for ready before raising valid.
  assign awready = (state == W_IDLE) || (state == W_HAVE_DATA);
  assign wready  = (state == W_IDLE) || (state == W_HAVE_ADDR);
  assign bvalid  = (state == W_RESP);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    commit    = 1'b0;
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    case (state)
      W_IDLE:      commit = aw_hs && w_hs;
      W_HAVE_ADDR: commit = w_hs;
      W_HAVE_DATA: commit = aw_hs;
      default:     commit = 1'b0;
    endcase
    waddr     = (state == W_HAVE_ADDR) ? addr_q : awaddr;
    wdata_out = (state == W_HAVE_DATA) ? data_q : wdata;
    ro_hit    = RO_ID_EN && (&waddr);
    we        = commit && !ro_hit;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      state  <= W_IDLE;
      addr_q <= '0;
      data_q <= '0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      state <= W_RESP;
      bresp <= ro_hit ? RESP_SLVERR : RESP_OKAY;
    end else begin
      case (state)
        W_IDLE: begin
          if (aw_hs) begin
            addr_q <= awaddr;
            state  <= W_HAVE_ADDR;
          end else if (w_hs) begin
            data_q <= wdata;
            state  <= W_HAVE_DATA;
          end
        end
        W_RESP:  if (bready) state <= W_IDLE;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave register file: 2^ADDR_WIDTH registers, independent write and read paths.
// Build option AXI_RO_ID_REG_EN: top register is read-only and returns ID_VALUE.
module axi4lite_slave_regfile
  import axi4lite_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 2,
  parameter int                  DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 8'hA5
) (
  input logic        clk,
  input logic        rst_n,
  axi4lite_if.slave  s
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  rd_state_e             rd_state;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  axi4lite_slave_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .awaddr    (s.s_awaddr),
    .awvalid   (s.s_awvalid),
    .awready   (s.s_awready),
    .wdata     (s.s_wdata),
    .wvalid    (s.s_wvalid),
    .wready    (s.s_wready),
    .bresp     (s.s_bresp),
    .bvalid    (s.s_bvalid),
    .bready    (s.s_bready),
    .we        (we),
    .waddr     (waddr),
    .wdata_out (wdata)
  );

  always_ff @(posedge clk) begin
    // NOTE: the array is reset on purpose; every register must read RESET_VALUE after reset.
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-edge write and read of one address returns the old value: regs updates after this sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s.s_arvalid) begin
            rdata_q  <= (RO_ID_EN && (&s.s_araddr)) ? ID_VALUE : regs[s.s_araddr];
            rresp_q  <= RESP_OKAY;
            rd_state <= R_RESP;
          end
        end
        R_RESP:  if (s.s_rready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign s.s_arready = (rd_state == R_IDLE);
  assign s.s_rvalid  = (rd_state == R_RESP);
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed self-checking bench for axi4lite_slave_regfile with B/R response scoreboards.
// Expectations follow AXI_RO_ID_REG_EN when it is defined.
module tb_axi4lite_slave_regfile;
  import axi4lite_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4lite_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

  axi4lite_slave_regfile #(
    .ADDR_WIDTH  (2),
    .DATA_WIDTH  (8),
    .RESET_VALUE (8'h00),
    .ID_VALUE    (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model [4];
  logic [1:0] b_q [$];
  logic [7:0] rd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
`ifdef AXI_RO_ID_REG_EN
    if (a == 2'd3) return 8'hA5;
`endif
    return model[a];
  endfunction

  function automatic logic [1:0] exp_b(input logic [1:0] a);
`ifdef AXI_RO_ID_REG_EN
    if (a == 2'd3) return RESP_SLVERR;
`endif
    return RESP_OKAY;
  endfunction

  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    if (exp_b(a) == RESP_OKAY) model[a] = d;
  endtask

  task automatic send_write(input logic [1:0] a, input logic [7:0] d);
    int cnt = 0;
    bus.s_awaddr  = a;
    bus.s_wdata   = d;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    b_q.push_back(exp_b(a));
    model_write(a, d);
    while (!(bus.s_awready && bus.s_wready) && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("aw_w_ready_wait", 32'(bus.s_awready && bus.s_wready), 1);
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    chk("b_latency", 32'(bus.s_bvalid), 1);
  endtask

  task automatic collect_b(input string tag);
    int cnt = 0;
    bus.s_bready = 1'b1;
    while (!bus.s_bvalid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_bvalid_wait"}, 32'(bus.s_bvalid), 1);
    if (b_q.size() > 0) chk({tag, "_bresp"}, 32'(bus.s_bresp), 32'(b_q.pop_front()));
    tick();
    bus.s_bready = 1'b0;
  endtask

  task automatic start_read(input logic [1:0] a);
    int cnt = 0;
    bus.s_araddr  = a;
    bus.s_arvalid = 1'b1;
    rd_q.push_back(exp_rd(a));
    while (!bus.s_arready && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("arready_wait", 32'(bus.s_arready), 1);
    tick();
    bus.s_arvalid = 1'b0;
    chk("r_latency", 32'(bus.s_rvalid), 1);
  endtask

  task automatic collect_r(input string tag);
    int cnt = 0;
    bus.s_rready = 1'b1;
    while (!bus.s_rvalid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_rvalid_wait"}, 32'(bus.s_rvalid), 1);
    if (rd_q.size() > 0) chk({tag, "_rdata"}, 32'(bus.s_rdata), 32'(rd_q.pop_front()));
    chk({tag, "_rresp"}, 32'(bus.s_rresp), 32'(RESP_OKAY));
    tick();
    bus.s_rready = 1'b0;
  endtask

  task automatic write_full(input logic [1:0] a, input logic [7:0] d, input string tag);
    send_write(a, d);
    collect_b(tag);
  endtask

  task automatic read_full(input logic [1:0] a, input string tag);
    start_read(a);
    collect_r(tag);
  endtask

  initial begin
    logic [7:0] held;
    rst_n         = 1'b0;
    bus.s_awaddr  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_bvalid", 32'(bus.s_bvalid), 0);
    chk("rst_rvalid", 32'(bus.s_rvalid), 0);
    chk("rst_bresp", 32'(bus.s_bresp), 0);
    chk("rst_rresp", 32'(bus.s_rresp), 0);
    chk("rst_rdata", 32'(bus.s_rdata), 0);
    chk("rst_awready", 32'(bus.s_awready), 1);
    chk("rst_wready", 32'(bus.s_wready), 1);
    chk("rst_arready", 32'(bus.s_arready), 1);

    // Read of a reset register
    read_full(2'd1, "rd_reset_val");

    // AW and W on the same edge, then read back
    write_full(2'd2, 8'h04, "wr_same_cycle");
    read_full(2'd2, "rd_addr2");

    // W three cycles ahead of AW, B held off for 4 cycles
    bus.s_wdata  = 8'h5C;
    bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    chk("have_data_awready", 32'(bus.s_awready), 1);
    chk("have_data_wready", 32'(bus.s_wready), 0);
    tick();
    tick();
    bus.s_awaddr  = 2'd1;
    bus.s_awvalid = 1'b1;
    b_q.push_back(exp_b(2'd1));
    model_write(2'd1, 8'h5C);
    tick();
    bus.s_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bhold_bvalid", 32'(bus.s_bvalid), 1);
      chk("bhold_awready", 32'(bus.s_awready), 0);
      chk("bhold_wready", 32'(bus.s_wready), 0);
      tick();
    end
    collect_b("wr_w_first");
    chk("post_b_awready", 32'(bus.s_awready), 1);
    read_full(2'd1, "rd_addr1");

    // Read held by rready=0 while the same address is written
    start_read(2'd3);
    held = exp_rd(2'd3);
    chk("rhold_rdata_0", 32'(bus.s_rdata), 32'(held));
    write_full(2'd3, 8'h77, "wr_addr3");
    for (int i = 0; i < 5; i++) begin
      chk("rhold_rvalid", 32'(bus.s_rvalid), 1);
      chk("rhold_rdata", 32'(bus.s_rdata), 32'(held));
      tick();
    end
    collect_r("rd_held");
    read_full(2'd3, "rd_addr3_new");

    // Same-edge write commit and read of address 0
    bus.s_awaddr  = 2'd0;
    bus.s_wdata   = 8'h33;
    bus.s_araddr  = 2'd0;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    bus.s_arvalid = 1'b1;
    rd_q.push_back(exp_rd(2'd0));
    b_q.push_back(exp_b(2'd0));
    model_write(2'd0, 8'h33);
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_arvalid = 1'b0;
    collect_b("wr_collide");
    collect_r("rd_collide_old");
    read_full(2'd0, "rd_collide_new");

    // Reset while write is in W_HAVE_ADDR and read is in R_RESP
    bus.s_awaddr  = 2'd2;
    bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_araddr  = 2'd1;
    bus.s_arvalid = 1'b1;
    tick();
    bus.s_arvalid = 1'b0;
    chk("pre_rst_rvalid", 32'(bus.s_rvalid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    b_q.delete();
    rd_q.delete();
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    chk("mid_rst_rvalid", 32'(bus.s_rvalid), 0);
    chk("mid_rst_rdata", 32'(bus.s_rdata), 0);
    chk("mid_rst_awready", 32'(bus.s_awready), 1);
    chk("mid_rst_wready", 32'(bus.s_wready), 1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_bvalid", 32'(bus.s_bvalid), 0);
      tick();
    end
    for (int i = 0; i < 4; i++) read_full(2'(i), "rd_after_rst");

    // Top register: read-only ID when enabled, ordinary register otherwise
    write_full(2'd3, 8'h11, "wr_top");
    read_full(2'd3, "rd_top");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_regfile.md
Name: axi4lite_slave_regfile

Overview:
AXI4-Lite slave register file that sits directly downstream of the AXI4-Lite master inside the tt_um_axi4lite top. It terminates all five channels (AW, W, B, AR, R) and holds 2^ADDR_WIDTH registers of DATA_WIDTH bits each. The master's write/read transactions land here, and its read data is sourced from here. The write and read paths are independent FSMs; each allows one outstanding transaction.

Parameters:
- ADDR_WIDTH, 2, register index width; the register count is 2^ADDR_WIDTH.
- DATA_WIDTH, 8, register and data-bus width.
- RESET_VALUE, 0, value loaded into every register on reset.
- ID_VALUE, 8'hA5, constant read from the top register; used only when AXI_RO_ID_REG_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  DATA_WIDTH  write data.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  ADDR_WIDTH  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  DATA_WIDTH  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Both FSMs go to idle.
  - All registers load RESET_VALUE.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - Reset mid-transaction drops that transaction silently; no response is issued.
- Handshake rule: a transfer occurs on an edge where valid&&ready. A slave valid, once high, stays high with payload stable until its ready.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - awready = state in {W_IDLE, W_HAVE_DATA}.
  - wready = state in {W_IDLE, W_HAVE_ADDR}.
  - Combinational from state only; never depends on valid.
  - W_IDLE: AW+W same edge -> commit, go to W_RESP. AW only -> latch addr, go to W_HAVE_ADDR. W only -> latch data, go to W_HAVE_DATA.
  - W_HAVE_ADDR: W handshake -> commit, go to W_RESP.
  - W_HAVE_DATA: AW handshake -> commit, go to W_RESP.
  - Commit writes the register on the same edge the final AW/W handshake occurs. bvalid=1 from that edge.
  - W_RESP: bvalid=1, bresp=OKAY. On bready, go to W_IDLE. The next AW/W is accepted one cycle later; there is no back-to-back overlap.
- Read FSM states: R_IDLE, R_RESP.
  - arready = (state==R_IDLE).
  - On AR handshake, rdata captures reg[araddr] and rvalid=1 from that edge, rresp=OKAY. Latency is 1 cycle.
  - R_RESP: rdata/rresp held stable. On rready, go to R_IDLE and rvalid=0. rdata keeps its last value.
- Simultaneous write commit and AR handshake to the same address on one edge: read returns the pre-write (old) value. The next read sees the new value.
- Read and write paths never stall each other.
- Address width is exact, so there is no out-of-range case and no wrap logic.

Optional Feature:
- AXI_RO_ID_REG_EN defined:
  - Register index 2^ADDR_WIDTH-1 is read-only and always reads ID_VALUE, with rresp=OKAY.
  - A write to it leaves storage unchanged and returns bresp=SLVERR (2'b10).
  - Reset does not affect the returned ID_VALUE.
- Undefined:
  - All registers are read/write.
  - Every response is OKAY.

Decomposition:
- Package axi4lite_pkg:
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Write FSM enum (W_IDLE/W_HAVE_ADDR/W_HAVE_DATA/W_RESP).
  - Read FSM enum (R_IDLE/R_RESP).
  - Shared with the master.
- Sub-module axi4lite_slave_wr_ctrl (write FSM, addr/data latches, B channel) is natural. The read path and register array stay in the top.

Test Plan:
- Reset then AR to addr 1 -> rvalid next cycle, rdata=RESET_VALUE (0x00), rresp=OKAY.
- AW=2 and W=0x04 same cycle, bready=1; then AR=2 -> bvalid 1 cycle after handshake, bresp=OKAY; rdata=0x04.
- W=0x5C three cycles before AW=1, with bready held 0 for 4 cycles -> awready/wready low while bvalid is held; reg1=0x5C; next AW accepted only after B completes.
- AR=3 with rready=0 for 5 cycles while writing 0x77 to addr 3 -> rvalid/rdata stable at old value for the whole 5 cycles; a second read returns 0x77.
- Same-edge write 0x33 to addr 0 and AR to addr 0 -> read returns old value 0x00; a subsequent read returns 0x33.
- rst_n=0 while in W_HAVE_ADDR and R_RESP -> bvalid=0, rvalid=0, all registers 0. With AXI_RO_ID_REG_EN, write 0x11 to addr 3 -> bresp=SLVERR, read returns 0xA5.
